// File: rtl/data_mem64_ram_pkg.sv
// Shared constants and types for the MEM-stage data memory.
package data_mem64_ram_pkg;

    localparam int unsigned XLEN       = 64;
    localparam int unsigned DMEM_DEPTH = 256;
    localparam int unsigned WORD_BYTES = 8;
    localparam int unsigned WORD_SHIFT = $clog2(WORD_BYTES);

    typedef logic [XLEN-1:0] xword_t;

endpackage

// File: rtl/data_mem64_ram_if.sv
// Load/store bus between the MEM-stage address/data path and the data memory.
interface data_mem64_ram_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
);

    logic              memread;
    logic              memwrite;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    modport master (
        output memread,
        output memwrite,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  memread,
        input  memwrite,
        input  addr,
        input  wdata,
        output rdata
    );

endinterface

// File: rtl/data_mem64_ram.sv
// 64-bit doubleword data memory: synchronous write, combinational read,
// asynchronous clear of the whole array on reset.
module data_mem64_ram
    import data_mem64_ram_pkg::*;
#(
    parameter int unsigned DEPTH  = DMEM_DEPTH,
    parameter int unsigned ADDR_W = XLEN,
    parameter int unsigned DATA_W = XLEN
) (
    input logic               clk,
    input logic               rst_n,
    data_mem64_ram_if.slave   bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] word_addr;
    logic [IDX_W-1:0]  idx;
    logic              in_range;

    // Byte offset is dropped; any bit set above the index puts the access out of range.
    always_comb begin
        word_addr = bus.addr >> WORD_SHIFT;
        idx       = word_addr[IDX_W-1:0];
        in_range  = (word_addr < ADDR_W'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.memwrite && in_range) begin
            mem[idx] <= bus.wdata;
        end
    end

    always_comb begin
        bus.rdata = '0;
        if (bus.memread && in_range) begin
            bus.rdata = mem[idx];
        end
    end

endmodule

// File: tb/tb_data_mem64_ram.sv
// Directed self-checking bench for data_mem64_ram.
module tb_data_mem64_ram;

    localparam int unsigned DEPTH = 256;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    data_mem64_ram_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    data_mem64_ram #(.DEPTH(DEPTH), .ADDR_W(64), .DATA_W(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_write(input logic [63:0] a, input logic [63:0] d);
        @(negedge clk);
        bus.memread  = 1'b0;
        bus.memwrite = 1'b1;
        bus.addr     = a;
        bus.wdata    = d;
        @(posedge clk);
        #1;
        bus.memwrite = 1'b0;
    endtask

    task automatic set_read(input logic [63:0] a, input logic rd);
        @(negedge clk);
        bus.memwrite = 1'b0;
        bus.memread  = rd;
        bus.addr     = a;
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        do_write(64'd0, 64'hFFFF_0000_FFFF_0000);
        do_write(64'd8, 64'h1111_2222_3333_4444);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        bus.memread = 1'b1;
        bus.addr    = 64'd0;
        #1;
        checks++;
        if (bus.rdata !== 64'h0) begin
            $display("FAIL reset_in_reset_addr0: got %h expected %h", bus.rdata, 64'h0);
            errors++;
        end
        // write attempted while reset is held must be blocked
        bus.memwrite = 1'b1;
        bus.wdata    = 64'hABCD;
        @(posedge clk);
        #1;
        bus.memwrite = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        set_read(64'd0, 1'b1);
        checks++;
        if (bus.rdata !== 64'h0) begin
            $display("FAIL reset_addr0: got %h expected %h", bus.rdata, 64'h0);
            errors++;
        end
        set_read(64'd8, 1'b1);
        checks++;
        if (bus.rdata !== 64'h0) begin
            $display("FAIL reset_addr8: got %h expected %h", bus.rdata, 64'h0);
            errors++;
        end
    endtask

    task automatic test_basic;
        do_write(64'd0, 64'hDEADBEEFCAFEBABE);
        set_read(64'd0, 1'b1);
        checks++;
        if (bus.rdata !== 64'hDEADBEEFCAFEBABE) begin
            $display("FAIL basic_read0: got %h expected %h", bus.rdata, 64'hDEADBEEFCAFEBABE);
            errors++;
        end
    endtask

    task automatic test_second_word;
        do_write(64'd8, 64'h0123456789ABCDEF);
        set_read(64'd8, 1'b1);
        checks++;
        if (bus.rdata !== 64'h0123456789ABCDEF) begin
            $display("FAIL second_read8: got %h expected %h", bus.rdata, 64'h0123456789ABCDEF);
            errors++;
        end
        set_read(64'd0, 1'b1);
        checks++;
        if (bus.rdata !== 64'hDEADBEEFCAFEBABE) begin
            $display("FAIL second_reread0: got %h expected %h", bus.rdata, 64'hDEADBEEFCAFEBABE);
            errors++;
        end
    endtask

    task automatic test_misaligned;
        set_read(64'd3, 1'b1);
        checks++;
        if (bus.rdata !== 64'hDEADBEEFCAFEBABE) begin
            $display("FAIL misaligned_3: got %h expected %h", bus.rdata, 64'hDEADBEEFCAFEBABE);
            errors++;
        end
        set_read(64'd15, 1'b1);
        checks++;
        if (bus.rdata !== 64'h0123456789ABCDEF) begin
            $display("FAIL misaligned_15: got %h expected %h", bus.rdata, 64'h0123456789ABCDEF);
            errors++;
        end
        // misaligned write lands in the enclosing word
        do_write(64'd21, 64'h5555_AAAA_5555_AAAA);
        set_read(64'd16, 1'b1);
        checks++;
        if (bus.rdata !== 64'h5555_AAAA_5555_AAAA) begin
            $display("FAIL misaligned_write21: got %h expected %h", bus.rdata, 64'h5555_AAAA_5555_AAAA);
            errors++;
        end
    endtask

    task automatic test_range;
        do_write(64'(DEPTH * 8 - 8), 64'hFEED_FACE_0BAD_F00D);
        set_read(64'(DEPTH * 8 - 1), 1'b1);
        checks++;
        if (bus.rdata !== 64'hFEED_FACE_0BAD_F00D) begin
            $display("FAIL range_last_word: got %h expected %h", bus.rdata, 64'hFEED_FACE_0BAD_F00D);
            errors++;
        end
        do_write(64'(DEPTH * 8), 64'h9999_9999_9999_9999);
        do_write(64'h8000_0000_0000_0000, 64'h7777_7777_7777_7777);
        do_write(64'h0000_0001_0000_0008, 64'h6666_6666_6666_6666);
        set_read(64'd0, 1'b1);
        checks++;
        if (bus.rdata !== 64'hDEADBEEFCAFEBABE) begin
            $display("FAIL range_alias0: got %h expected %h", bus.rdata, 64'hDEADBEEFCAFEBABE);
            errors++;
        end
        set_read(64'd8, 1'b1);
        checks++;
        if (bus.rdata !== 64'h0123456789ABCDEF) begin
            $display("FAIL range_alias8: got %h expected %h", bus.rdata, 64'h0123456789ABCDEF);
            errors++;
        end
        set_read(64'(DEPTH * 8), 1'b1);
        checks++;
        if (bus.rdata !== 64'h0) begin
            $display("FAIL range_read_oob: got %h expected %h", bus.rdata, 64'h0);
            errors++;
        end
        set_read(64'h8000_0000_0000_0000, 1'b1);
        checks++;
        if (bus.rdata !== 64'h0) begin
            $display("FAIL range_read_high: got %h expected %h", bus.rdata, 64'h0);
            errors++;
        end
    endtask

    task automatic test_disable;
        set_read(64'd0, 1'b0);
        checks++;
        if (bus.rdata !== 64'h0) begin
            $display("FAIL disable_read0: got %h expected %h", bus.rdata, 64'h0);
            errors++;
        end
        set_read(64'd8, 1'b0);
        checks++;
        if (bus.rdata !== 64'h0) begin
            $display("FAIL disable_read8: got %h expected %h", bus.rdata, 64'h0);
            errors++;
        end
        // memwrite low across an edge leaves contents untouched
        @(negedge clk);
        bus.memwrite = 1'b0;
        bus.addr     = 64'd0;
        bus.wdata    = 64'h1234_1234_1234_1234;
        @(posedge clk);
        #1;
        set_read(64'd0, 1'b1);
        checks++;
        if (bus.rdata !== 64'hDEADBEEFCAFEBABE) begin
            $display("FAIL nowrite_read0: got %h expected %h", bus.rdata, 64'hDEADBEEFCAFEBABE);
            errors++;
        end
    endtask

    task automatic test_read_during_write;
        @(negedge clk);
        bus.memread  = 1'b1;
        bus.memwrite = 1'b1;
        bus.addr     = 64'd0;
        bus.wdata    = 64'h1;
        #1;
        checks++;
        if (bus.rdata !== 64'hDEADBEEFCAFEBABE) begin
            $display("FAIL rdw_before_edge: got %h expected %h", bus.rdata, 64'hDEADBEEFCAFEBABE);
            errors++;
        end
        // combinational tracking of addr inside the same cycle
        bus.addr = 64'd8;
        #1;
        checks++;
        if (bus.rdata !== 64'h0123456789ABCDEF) begin
            $display("FAIL rdw_track_addr: got %h expected %h", bus.rdata, 64'h0123456789ABCDEF);
            errors++;
        end
        bus.addr = 64'd0;
        @(posedge clk);
        #1;
        bus.memwrite = 1'b0;
        checks++;
        if (bus.rdata !== 64'h1) begin
            $display("FAIL rdw_after_edge: got %h expected %h", bus.rdata, 64'h1);
            errors++;
        end
    endtask

    task automatic test_reset_mid_write;
        @(negedge clk);
        bus.memread  = 1'b0;
        bus.memwrite = 1'b1;
        bus.addr     = 64'd24;
        bus.wdata    = 64'hCCCC_DDDD_EEEE_FFFF;
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        bus.memwrite = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        set_read(64'd24, 1'b1);
        checks++;
        if (bus.rdata !== 64'h0) begin
            $display("FAIL rstmid_word24: got %h expected %h", bus.rdata, 64'h0);
            errors++;
        end
        set_read(64'd0, 1'b1);
        checks++;
        if (bus.rdata !== 64'h0) begin
            $display("FAIL rstmid_word0: got %h expected %h", bus.rdata, 64'h0);
            errors++;
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        bus.memread  = 1'b0;
        bus.memwrite = 1'b0;
        bus.addr     = '0;
        bus.wdata    = '0;
        test_reset();
        test_basic();
        test_second_word();
        test_misaligned();
        test_range();
        test_disable();
        test_read_during_write();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
